// File: rtl/regbank_reader.sv
// Sequential read-out engine for the banked register file: walks physical entries or
// one mode's logical view and streams tagged data over a valid/ready handshake.
module regbank_reader #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          view,
   input  logic [4:0]    mode_sel,
   input  logic          abort,
   output logic          rf_re,
   output logic [4:0]    rf_raddr,
   input  logic [DW-1:0] rf_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [4:0]    out_mode,
   output logic [3:0]    out_reg,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   localparam int unsigned IW = 5;
   localparam logic [4:0] MODE_USR = 5'b10000;
   localparam logic [4:0] MODE_FIQ = 5'b10001;
   localparam logic [4:0] MODE_IRQ = 5'b10010;
   localparam logic [4:0] MODE_SVC = 5'b10011;
   localparam logic [4:0] MODE_ABT = 5'b10111;
   localparam logic [4:0] MODE_UND = 5'b11011;
   localparam logic [IW-1:0] FULL_LAST = IW'(30);
   localparam logic [IW-1:0] VIEW_LAST = IW'(15);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, PRESENT} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            view_q, view_d;
   logic [4:0]      mode_q, mode_d;
   logic            rf_re_q, rf_re_d;
   logic [4:0]      rf_raddr_q, rf_raddr_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic [4:0]      out_mode_q, out_mode_d;
   logic [3:0]      out_reg_q, out_reg_d;
   logic            out_last_q, out_last_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   // Forward map: (view, mode, index) -> physical address; full walk uses the index directly.
   function automatic logic [4:0] fwd_addr(input logic v, input logic [4:0] m,
                                           input logic [IW-1:0] idx);
      logic [4:0] i;
      i = {1'b0, idx[3:0]};
      fwd_addr = idx;
      if (v) begin
         fwd_addr = i;
         case (m)
            MODE_FIQ: if (i >= 5'd8 && i <= 5'd14) fwd_addr = i + 5'd8;
            MODE_SVC: if (i >= 5'd13) begin if (i <= 5'd14) fwd_addr = i + 5'd10; end
            MODE_ABT: if (i >= 5'd13) begin if (i <= 5'd14) fwd_addr = i + 5'd12; end
            MODE_IRQ: if (i >= 5'd13) begin if (i <= 5'd14) fwd_addr = i + 5'd14; end
            MODE_UND: if (i >= 5'd13) begin if (i <= 5'd14) fwd_addr = i + 5'd16; end
            default: ;
         endcase
      end
   endfunction

   // Inverse map: physical address -> {owning mode, logical register}.
   function automatic logic [8:0] phys_tag(input logic [4:0] p);
      logic [3:0] r;
      r = p[0] ? 4'd13 : 4'd14;
      if (p < 5'h10)       phys_tag = {MODE_USR, p[3:0]};
      else if (p < 5'h17)  phys_tag = {MODE_FIQ, 4'(p - 5'd8)};
      else if (p < 5'h19)  phys_tag = {MODE_SVC, r};
      else if (p < 5'h1B)  phys_tag = {MODE_ABT, r};
      else if (p < 5'h1D)  phys_tag = {MODE_IRQ, r};
      else                 phys_tag = {MODE_UND, r};
   endfunction

   function automatic logic is_last(input logic v, input logic [IW-1:0] idx);
      is_last = v ? (idx == VIEW_LAST) : (idx == FULL_LAST);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         view_q      <= 1'b0;
         mode_q      <= '0;
         rf_re_q     <= 1'b0;
         rf_raddr_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mode_q  <= '0;
         out_reg_q   <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         view_q      <= view_d;
         mode_q      <= mode_d;
         rf_re_q     <= rf_re_d;
         rf_raddr_q  <= rf_raddr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_mode_q  <= out_mode_d;
         out_reg_q   <= out_reg_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next state; registered outputs are derived from the next state so they align with it.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      view_d     = view_q;
      mode_d     = mode_q;
      out_data_d = out_data_q;
      out_mode_d = out_mode_q;
      out_reg_d  = out_reg_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = ISSUE;
               view_d  = view;
               mode_d  = mode_sel;
               idx_d   = '0;
            end
         end
         ISSUE: state_d = CAPT;
         CAPT: begin
            state_d    = PRESENT;
            out_data_d = rf_rdata;
            if (view_q) {out_mode_d, out_reg_d} = {mode_q, idx_q[3:0]};
            else        {out_mode_d, out_reg_d} = phys_tag(idx_q);
         end
         PRESENT: begin
            if (out_ready) begin
               if (is_last(view_q, idx_q)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ISSUE;
                  idx_d   = idx_q + IW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over acceptance and capture.
      if (abort && state_q != IDLE) begin
         state_d    = IDLE;
         idx_d      = idx_q;
         out_data_d = out_data_q;
         out_mode_d = out_mode_q;
         out_reg_d  = out_reg_q;
         done_d     = 1'b0;
      end

      rf_re_d     = (state_d == ISSUE);
      rf_raddr_d  = rf_re_d ? fwd_addr(view_d, mode_d, idx_d) : 5'd0;
      out_valid_d = (state_d == PRESENT);
      out_last_d  = (state_d == PRESENT) && is_last(view_d, idx_d);
      busy_d      = (state_d != IDLE);
   end

   assign rf_re     = rf_re_q;
   assign rf_raddr  = rf_raddr_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_mode  = out_mode_q;
   assign out_reg   = out_reg_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: doc/regbank_reader.md
# regbank_reader

Sequential read-out engine for the banked register file: the inverse of the mode/register-field address mapper. It walks the 31 physical register entries (or the 16-entry logical view of one processor mode) and streams each entry's data tagged with its owning mode and logical register number. It sits between the register file's debug read port and the debug/context-save logic. Output is on a valid/ready handshake.

## Interface
Parameters:
- DW, 32, register data width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a dump; sampled only in IDLE
- view  in  1  0 = full physical walk (31 entries), 1 = logical view of mode_sel (16 entries); captured at start
- mode_sel  in  5  CPSR mode encoding for view walk; captured at start
- abort  in  1  synchronous cancel
- rf_re  out  1  register-file read enable
- rf_raddr  out  5  physical register address
- rf_rdata  in  DW  read data, valid the cycle after rf_re
- out_valid  out  1  entry available
- out_ready  in  1  consumer accepts entry
- out_data  out  DW  register contents
- out_mode  out  5  owning mode tag
- out_reg  out  4  logical register number r0–r15
- out_last  out  1  final entry of the walk
- busy  out  1  walk in progress
- done  out  1  one-cycle pulse after the final entry is accepted

## Operation
- Physical map: 0x00–0x0F = USR r0–r15; 0x10–0x16 = FIQ r8–r14; 0x17/0x18 = SVC r13/r14; 0x19/0x1A = ABT r13/r14; 0x1B/0x1C = IRQ r13/r14; 0x1D/0x1E = UND r13/r14. Address 0x1F is never read.
- Mode encodings use the pardef macros: USR 5'b10000, FIQ 5'b10001, IRQ 5'b10010, SVC 5'b10011, ABT 5'b10111, UND (`UNDE) 5'b11011.
- Full walk:
  - Index p runs from 0x00 to 0x1E with rf_raddr = p.
  - Each entry is tagged from the physical map, inverted. For example, 0x15 → FIQ/r13 and 0x1C → IRQ/r14.
- View walk:
  - Index i runs from 0 to 15 with out_reg = i and out_mode = captured mode_sel.
  - rf_raddr = forward map(mode_sel, i): FIQ banks r8–r14; SVC/ABT/IRQ/UND bank r13–r14.
  - Any other mode, including SYS 5'b11111 and unknown encodings, uses {1'b0, i}.
- FSM states: IDLE, ISSUE, CAPT, PRESENT.
  - IDLE → ISSUE when start=1 and abort=0. Capture view and mode_sel, and clear the index.
  - ISSUE: rf_re=1 and rf_raddr = address of the current index. Always → CAPT.
  - CAPT: on the clock edge, out_data ← rf_rdata, tags ← current index, out_valid ← 1. → PRESENT.
  - PRESENT: hold out_valid and all out_* stable until out_ready=1.
    - On acceptance of a non-last entry: increment the index, drop out_valid, → ISSUE.
    - On acceptance of the last entry: → IDLE, drop out_valid, assert done for one cycle.
- out_last = 1 in PRESENT when the index is 30 (full walk) or 15 (view walk).
- busy = 1 in ISSUE, CAPT and PRESENT.
- rf_raddr is 0 whenever rf_re=0.
- start is ignored while busy.
- abort = 1 in any non-IDLE state:
  - → IDLE on the next edge, out_valid drops, no done pulse.
  - abort beats out_ready in the same PRESENT cycle (the entry is not accepted).
  - abort together with start in IDLE means stay in IDLE.
- Reset (any time, including mid-walk): state IDLE; all outputs 0 (rf_re, rf_raddr, out_valid, out_data, out_mode, out_reg, out_last, busy, done); index 0.

## Timing
- start high in cycle 0 gives ISSUE in cycle 1, CAPT in cycle 2, and the first out_valid in cycle 3.
- With out_ready held high, entry n is valid in cycle 3+3n (3 cycles per entry).
- Each cycle of out_ready=0 in PRESENT adds one cycle.
- done pulses in the cycle after the last acceptance; busy is low in that same cycle.
- A new start is accepted in the done cycle.
- out_* are registered; there is no combinational path from out_ready to out_valid.

## Test plan
- Full walk with out_ready=1 and rf_rdata = {27'h0, rf_raddr} from the previous cycle:
  - 31 entries, with entry n valid in cycle 3+3n.
  - 0x15 → FIQ/r13 with data 0x15; 0x1E → UND/r14 with out_last=1 in cycle 93.
  - done in cycle 94; rf_raddr 0x1F never driven.
- View walk with mode_sel=FIQ: 16 entries; r7 reads 0x07, r8 reads 0x10, r14 reads 0x16, r15 reads 0x0F. out_mode=5'b10001 throughout.
- View walk with mode_sel=SVC, then ABT, IRQ, UND, SYS, and 5'b00000:
  - r13/r14 read 0x17/0x18, 0x19/0x1A, 0x1B/0x1C, 0x1D/0x1E respectively.
  - SYS and 5'b00000 read 0x0D/0x0E.
  - All other registers read the identity address.
- Backpressure: out_ready toggles 0,0,1 per entry. out_data and tags stay stable while stalled, each entry takes 5 cycles, and no entry is duplicated or dropped.
- Abort in PRESENT of entry 5 with out_ready=1 in the same cycle: the entry is not accepted, IDLE on the next cycle, no done. A start then restarts from index 0. A start during busy is ignored.
- Reset asserted asynchronously mid-CAPT: all outputs 0 immediately. After release, the block stays idle until start.
